// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EXE bus, waits for load data, extracts and extends it.
// Optional load-stall counter enabled by defining MEM_STALL_CNT_EN.
module mem_stage #(
  parameter int unsigned EXE_BUS_W = 103,
  parameter int unsigned WB_BUS_W  = 102
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 EXE_to_MEM_valid,
  input  logic [EXE_BUS_W-1:0] EXE_to_MEM_bus,
  output logic                 MEM_allow_in,
  output logic                 MEM_to_WB_valid,
  input  logic                 WB_allow_in,
  output logic [WB_BUS_W-1:0]  MEM_to_WB_bus,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 data_sram_data_ok,
  output logic [38:0]          MEM_wr_bus,
  output logic [31:0]          mem_stall_cnt
);

  localparam logic [9:0] OpLdB  = 10'b0010100000;
  localparam logic [9:0] OpLdH  = 10'b0010100001;
  localparam logic [9:0] OpLdW  = 10'b0010100010;
  localparam logic [9:0] OpLdBu = 10'b0010101000;
  localparam logic [9:0] OpLdHu = 10'b0010101001;

  logic                 mem_valid_q;
  logic [EXE_BUS_W-1:0] bus_q;
  logic                 rbuf_valid_q;
  logic [31:0]          rbuf_q;

  logic [31:0] exe_result;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] pc;
  logic [31:0] inst;

  logic        ready_go;
  logic        wb_fire;
  logic        rbuf_capture;
  logic [31:0] rdata_sel;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign exe_result   = bus_q[102:71];
  assign res_from_mem = bus_q[70];
  assign gr_we        = bus_q[69];
  assign dest         = bus_q[68:64];
  assign pc           = bus_q[63:32];
  assign inst         = bus_q[31:0];

  assign ready_go        = ~res_from_mem | rbuf_valid_q | data_sram_data_ok;
  assign MEM_to_WB_valid = mem_valid_q & ready_go;
  assign MEM_allow_in    = ~mem_valid_q | (MEM_to_WB_valid & WB_allow_in);
  assign wb_fire         = MEM_to_WB_valid & WB_allow_in;

  // Hold load data that arrives while writeback is stalled; the SRAM will not repeat it.
  assign rbuf_capture = data_sram_data_ok & mem_valid_q & res_from_mem & ~rbuf_valid_q &
                        ~WB_allow_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q  <= 1'b0;
      rbuf_valid_q <= 1'b0;
    end else begin
      if (MEM_allow_in) begin
        mem_valid_q <= EXE_to_MEM_valid;
      end
      if (wb_fire) begin
        rbuf_valid_q <= 1'b0;
      end else if (rbuf_capture) begin
        rbuf_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (EXE_to_MEM_valid && MEM_allow_in) begin
      bus_q <= EXE_to_MEM_bus;
    end
    if (rbuf_capture) begin
      rbuf_q <= data_sram_rdata;
    end
  end

  assign rdata_sel = rbuf_valid_q ? rbuf_q : data_sram_rdata;

  always_comb begin
    byte_sel = rdata_sel[7:0];
    case (exe_result[1:0])
      2'd0:    byte_sel = rdata_sel[7:0];
      2'd1:    byte_sel = rdata_sel[15:8];
      2'd2:    byte_sel = rdata_sel[23:16];
      default: byte_sel = rdata_sel[31:24];
    endcase
    half_sel = exe_result[1] ? rdata_sel[31:16] : rdata_sel[15:0];
  end

  always_comb begin
    load_data = rdata_sel;
    case (inst[31:22])
      OpLdB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OpLdBu:  load_data = {24'd0, byte_sel};
      OpLdH:   load_data = {{16{half_sel[15]}}, half_sel};
      OpLdHu:  load_data = {16'd0, half_sel};
      OpLdW:   load_data = rdata_sel;
      default: load_data = rdata_sel;
    endcase
  end

  assign final_result  = res_from_mem ? load_data : exe_result;
  assign MEM_to_WB_bus = {final_result, gr_we, dest, pc, inst};
  assign MEM_wr_bus    = {mem_valid_q & gr_we, mem_valid_q & res_from_mem & ~ready_go,
                          dest, final_result};

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (mem_valid_q && res_from_mem && !ready_go) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign mem_stall_cnt = stall_cnt_q;
`else
  assign mem_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: randomized traffic against a behavioural load model.
module tb_mem_stage;

  localparam logic [9:0] LDB  = 10'b0010100000;
  localparam logic [9:0] LDH  = 10'b0010100001;
  localparam logic [9:0] LDW  = 10'b0010100010;
  localparam logic [9:0] LDBU = 10'b0010101000;
  localparam logic [9:0] LDHU = 10'b0010101001;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         EXE_to_MEM_valid = 1'b0;
  logic [102:0] EXE_to_MEM_bus = '0;
  logic         MEM_allow_in;
  logic         MEM_to_WB_valid;
  logic         WB_allow_in = 1'b1;
  logic [101:0] MEM_to_WB_bus;
  logic [31:0]  data_sram_rdata = '0;
  logic         data_sram_data_ok = 1'b0;
  logic [38:0]  MEM_wr_bus;
  logic [31:0]  mem_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .EXE_to_MEM_valid (EXE_to_MEM_valid),
    .EXE_to_MEM_bus   (EXE_to_MEM_bus),
    .MEM_allow_in     (MEM_allow_in),
    .MEM_to_WB_valid  (MEM_to_WB_valid),
    .WB_allow_in      (WB_allow_in),
    .MEM_to_WB_bus    (MEM_to_WB_bus),
    .data_sram_rdata  (data_sram_rdata),
    .data_sram_data_ok(data_sram_data_ok),
    .MEM_wr_bus       (MEM_wr_bus),
    .mem_stall_cnt    (mem_stall_cnt)
  );

  function automatic logic [102:0] mk_bus(input logic [31:0] res, input logic rfm, input logic we,
                                          input logic [4:0] dst, input logic [31:0] pc,
                                          input logic [31:0] inst);
    return {res, rfm, we, dst, pc, inst};
  endfunction

  // Reference load semantics: shift the addressed lane down, mask, sign-extend arithmetically.
  function automatic logic [31:0] ref_load(input logic [9:0] op, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (op)
      LDB:     return (b ^ 32'h80) - 32'h80;
      LDBU:    return b;
      LDH:     return (h ^ 32'h8000) - 32'h8000;
      LDHU:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [9:0] rand_load_op();
    case ($urandom_range(0, 4))
      0:       return LDB;
      1:       return LDH;
      2:       return LDW;
      3:       return LDBU;
      default: return LDHU;
    endcase
  endfunction

  task automatic send(input logic [102:0] bus);
    EXE_to_MEM_valid = 1'b1;
    EXE_to_MEM_bus   = bus;
    @(posedge clk); #1;
    EXE_to_MEM_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++; if (MEM_to_WB_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid got %b exp 0", MEM_to_WB_valid); end
    n_tests++; if (MEM_allow_in !== 1'b1) begin n_fail++;
      $display("FAIL reset_allow_in got %b exp 1", MEM_allow_in); end
    n_tests++; if (MEM_wr_bus[38:37] !== 2'b00) begin n_fail++;
      $display("FAIL reset_wr_flags got %b exp 00", MEM_wr_bus[38:37]); end
    n_tests++; if (mem_stall_cnt !== 32'd0) begin n_fail++;
      $display("FAIL reset_cnt got %h exp 0", mem_stall_cnt); end
    reset = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_alu();
    logic [31:0] res, pc, inst;
    logic        we;
    logic [4:0]  dst;
    WB_allow_in = 1'b1;
    for (int i = 0; i < 21; i++) begin
      res  = (i == 0) ? 32'h12345678 : $urandom;
      we   = (i == 0) ? 1'b1 : 1'($urandom);
      dst  = (i == 0) ? 5'd5 : 5'($urandom);
      pc   = $urandom;
      inst = $urandom;
      data_sram_data_ok = 1'($urandom);
      data_sram_rdata   = $urandom;
      send(mk_bus(res, 1'b0, we, dst, pc, inst));
      n_tests++; if (MEM_to_WB_valid !== 1'b1) begin n_fail++;
        $display("FAIL alu_valid[%0d] got %b exp 1", i, MEM_to_WB_valid); end
      n_tests++; if (MEM_to_WB_bus !== {res, we, dst, pc, inst}) begin n_fail++;
        $display("FAIL alu_wb_bus[%0d] got %h exp %h", i, MEM_to_WB_bus, {res, we, dst, pc, inst});
      end
      n_tests++; if (MEM_wr_bus !== {we, 1'b0, dst, res}) begin n_fail++;
        $display("FAIL alu_wr_bus[%0d] got %h exp %h", i, MEM_wr_bus, {we, 1'b0, dst, res}); end
    end
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_load_same_cycle();
    logic [9:0]  op;
    logic [1:0]  a;
    logic [31:0] w, res, exp;
    logic [9:0]  dops [4] = '{LDB, LDBU, LDHU, LDH};
    logic [1:0]  daddr[4] = '{2'd3, 2'd3, 2'd2, 2'd0};
    WB_allow_in = 1'b1;
    for (int i = 0; i < 24; i++) begin
      op  = (i < 4) ? dops[i] : rand_load_op();
      a   = (i < 4) ? daddr[i] : 2'($urandom);
      w   = (i < 4) ? 32'h80FF0011 : $urandom;
      res = {30'($urandom), a};
      data_sram_data_ok = 1'b0;
      send(mk_bus(res, 1'b1, 1'b1, 5'd7, 32'h1000, {op, 22'($urandom)}));
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = w;
      #1;
      exp = ref_load(op, a, w);
      n_tests++; if (MEM_to_WB_valid !== 1'b1) begin n_fail++;
        $display("FAIL ld_valid[%0d] got %b exp 1", i, MEM_to_WB_valid); end
      n_tests++; if (MEM_to_WB_bus[101:70] !== exp) begin n_fail++;
        $display("FAIL ld_result[%0d] op %b a %0d got %h exp %h", i, op, a,
                 MEM_to_WB_bus[101:70], exp); end
      n_tests++; if (MEM_wr_bus[38:37] !== 2'b10) begin n_fail++;
        $display("FAIL ld_wr_flags[%0d] got %b exp 10", i, MEM_wr_bus[38:37]); end
      @(posedge clk); #1;
      data_sram_data_ok = 1'b0;
    end
  endtask

  task automatic test_load_delay();
    logic [9:0]  op;
    logic [1:0]  a;
    logic [31:0] w, exp;
    int          delay;
    do_reset();
    WB_allow_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      op    = (k == 0) ? LDW : rand_load_op();
      a     = 2'($urandom);
      w     = (k == 0) ? 32'hCAFEBABE : $urandom;
      delay = (k == 0) ? 3 : $urandom_range(0, 4);
      data_sram_data_ok = 1'b0;
      send(mk_bus({30'($urandom), a}, 1'b1, 1'b1, 5'd9, 32'h2000, {op, 22'($urandom)}));
      for (int d = 0; d < delay; d++) begin
        data_sram_rdata = $urandom;
        #1;
        n_tests++; if ({MEM_wr_bus[37], MEM_allow_in, MEM_to_WB_valid} !== 3'b100) begin
          n_fail++; $display("FAIL stall[%0d.%0d] block/allow/valid got %b exp 100", k, d,
                             {MEM_wr_bus[37], MEM_allow_in, MEM_to_WB_valid}); end
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 32'd1;
      end
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = w;
      #1;
      exp = ref_load(op, a, w);
      n_tests++; if (MEM_to_WB_valid !== 1'b1 || MEM_wr_bus[37] !== 1'b0) begin n_fail++;
        $display("FAIL delay_valid[%0d] valid %b block %b exp 1 0", k, MEM_to_WB_valid,
                 MEM_wr_bus[37]); end
      n_tests++; if (MEM_to_WB_bus[101:70] !== exp) begin n_fail++;
        $display("FAIL delay_result[%0d] got %h exp %h", k, MEM_to_WB_bus[101:70], exp); end
`ifdef MEM_STALL_CNT_EN
      n_tests++; if (mem_stall_cnt !== exp_cnt) begin n_fail++;
        $display("FAIL stall_cnt[%0d] got %0d exp %0d", k, mem_stall_cnt, exp_cnt); end
`else
      n_tests++; if (mem_stall_cnt !== 32'd0) begin n_fail++;
        $display("FAIL stall_cnt_off[%0d] got %0d exp 0", k, mem_stall_cnt); end
`endif
      @(posedge clk); #1;
      data_sram_data_ok = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    WB_allow_in = 1'b1;
    data_sram_data_ok = 1'b0;
    send(mk_bus(32'h3000, 1'b1, 1'b1, 5'd3, 32'h3000, {LDW, 22'd0}));
    WB_allow_in       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEADBEEF;
    #1;
    n_tests++; if (MEM_to_WB_valid !== 1'b1 || MEM_allow_in !== 1'b0) begin n_fail++;
      $display("FAIL bp_pulse valid %b allow %b exp 1 0", MEM_to_WB_valid, MEM_allow_in); end
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (MEM_to_WB_bus[101:70] !== 32'hDEADBEEF || MEM_to_WB_valid !== 1'b1 ||
                     MEM_allow_in !== 1'b0) begin n_fail++;
        $display("FAIL bp_hold[%0d] result %h valid %b allow %b exp deadbeef 1 0", i,
                 MEM_to_WB_bus[101:70], MEM_to_WB_valid, MEM_allow_in); end
      @(posedge clk); #1;
    end
    WB_allow_in = 1'b1;
    #1;
    n_tests++; if (MEM_to_WB_bus[101:70] !== 32'hDEADBEEF || MEM_allow_in !== 1'b1) begin
      n_fail++; $display("FAIL bp_release result %h allow %b exp deadbeef 1",
                         MEM_to_WB_bus[101:70], MEM_allow_in); end
    @(posedge clk); #1;
    n_tests++; if (MEM_to_WB_valid !== 1'b0) begin n_fail++;
      $display("FAIL bp_drain got %b exp 0", MEM_to_WB_valid); end
    // A fresh load must wait for its own data, proving the buffer was released.
    send(mk_bus(32'h3004, 1'b1, 1'b1, 5'd4, 32'h3004, {LDW, 22'd0}));
    #1;
    n_tests++; if (MEM_wr_bus[37] !== 1'b1 || MEM_to_WB_valid !== 1'b0) begin n_fail++;
      $display("FAIL bp_rbuf_clear block %b valid %b exp 1 0", MEM_wr_bus[37], MEM_to_WB_valid);
    end
    w = $urandom;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = w;
    #1;
    n_tests++; if (MEM_to_WB_bus[101:70] !== w) begin n_fail++;
      $display("FAIL bp_next_result got %h exp %h", MEM_to_WB_bus[101:70], w); end
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [101:0] exp_prev;
    logic [31:0]  res, pc, inst;
    logic         we;
    logic [4:0]   dst;
    WB_allow_in = 1'b1;
    exp_prev = '0;
    for (int i = 0; i < 16; i++) begin
      res = $urandom; pc = $urandom; inst = $urandom;
      we = 1'($urandom); dst = 5'($urandom);
      EXE_to_MEM_valid = 1'b1;
      EXE_to_MEM_bus   = mk_bus(res, 1'b0, we, dst, pc, inst);
      #1;
      n_tests++; if (MEM_allow_in !== 1'b1) begin n_fail++;
        $display("FAIL b2b_allow[%0d] got %b exp 1", i, MEM_allow_in); end
      if (i > 0) begin
        n_tests++; if (MEM_to_WB_valid !== 1'b1 || MEM_to_WB_bus !== exp_prev) begin n_fail++;
          $display("FAIL b2b_out[%0d] valid %b bus %h exp %h", i, MEM_to_WB_valid,
                   MEM_to_WB_bus, exp_prev); end
      end
      exp_prev = {res, we, dst, pc, inst};
      @(posedge clk); #1;
    end
    EXE_to_MEM_valid = 1'b0;
    #1;
    n_tests++; if (MEM_to_WB_valid !== 1'b1 || MEM_to_WB_bus !== exp_prev) begin n_fail++;
      $display("FAIL b2b_last valid %b bus %h exp %h", MEM_to_WB_valid, MEM_to_WB_bus, exp_prev);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    WB_allow_in = 1'b1;
    data_sram_data_ok = 1'b0;
    send(mk_bus(32'h4000, 1'b1, 1'b1, 5'd6, 32'h4000, {LDW, 22'd0}));
    #1;
    n_tests++; if (MEM_wr_bus[37] !== 1'b1) begin n_fail++;
      $display("FAIL rst_mid_pending block got %b exp 1", MEM_wr_bus[37]); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = $urandom;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if ({MEM_to_WB_valid, MEM_wr_bus[38:37], MEM_allow_in} !== 4'b0001) begin
        n_fail++; $display("FAIL rst_mid[%0d] valid/flags/allow got %b exp 0001", i,
                           {MEM_to_WB_valid, MEM_wr_bus[38:37], MEM_allow_in}); end
      n_tests++; if (mem_stall_cnt !== 32'd0) begin n_fail++;
        $display("FAIL rst_mid_cnt[%0d] got %0d exp 0", i, mem_stall_cnt); end
      @(posedge clk); #1;
    end
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    exp_cnt = 32'd0;
    test_reset();
    test_alu();
    test_load_same_cycle();
    test_load_delay();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage and upstream of writeback.
- Latches the execute-to-memory bus under valid/allow_in handshake.
- For loads, waits for the data-SRAM response, then byte/halfword-selects and sign/zero-extends the read data into the final result.
- Forwards a write/blocking bus to decode for bypass and load-use stall, and passes the result to writeback.

Parameters:
- EXE_BUS_W, 103, width of incoming bus {exe_result[31:0], res_from_mem, gr_we, dest[4:0], pc[31:0], inst[31:0]}
- WB_BUS_W, 102, width of outgoing bus {final_result[31:0], gr_we, dest[4:0], pc[31:0], inst[31:0]}

Ports:
- clk  in  1  sole clock, all state on posedge
- reset  in  1  synchronous, active-high
- EXE_to_MEM_valid  in  1  upstream has a valid instruction
- EXE_to_MEM_bus  in  EXE_BUS_W  upstream payload
- MEM_allow_in  out  1  stage can accept this cycle
- MEM_to_WB_valid  out  1  stage offers a finished instruction
- WB_allow_in  in  1  writeback accepts
- MEM_to_WB_bus  out  WB_BUS_W  downstream payload
- data_sram_rdata  in  32  load data, word-aligned
- data_sram_data_ok  in  1  rdata valid this cycle; tie 1 for synchronous one-cycle SRAM
- MEM_wr_bus  out  39  {MEM_write, MEM_block, dest[4:0], final_result[31:0]} to decode
- mem_stall_cnt  out  32  load-wait cycle count (see Optional Feature)

Behaviour:
- Registers:
  - MEM_valid, reset 0.
  - Bus register, loaded when EXE_to_MEM_valid & MEM_allow_in; no reset needed; outputs gated by MEM_valid.
  - MEM_valid <= EXE_to_MEM_valid whenever MEM_allow_in.
- Handshake:
  - ready_go = ~res_from_mem | rbuf_valid | data_sram_data_ok.
  - MEM_to_WB_valid = MEM_valid & ready_go.
  - MEM_allow_in = ~MEM_valid | (MEM_to_WB_valid & WB_allow_in).
- Read-data buffer (rbuf, rbuf_valid):
  - On data_sram_data_ok & MEM_valid & res_from_mem & ~rbuf_valid & ~WB_allow_in: capture rdata and set rbuf_valid.
  - Clear rbuf_valid on MEM_to_WB_valid & WB_allow_in. Clear has priority over capture; capture cannot occur in the same cycle by construction.
  - rdata_sel = rbuf_valid ? rbuf : data_sram_rdata.
  - data_ok while ~MEM_valid, or on a non-load, or while rbuf_valid is already set: ignored.
- Load decode, inst[31:22]:
  - ld.b 0010100000
  - ld.h 0010100001
  - ld.w 0010100010
  - ld.bu 0010101000
  - ld.hu 0010101001
- Load extract (a = exe_result[1:0]):
  - byte = rdata_sel[8a+7:8a]
  - half = a[1] ? rdata_sel[31:16] : rdata_sel[15:0]; a[0] is ignored for halfwords and a[1:0] is ignored for ld.w; no alignment exception in this stage.
  - ld.b/ld.h sign-extend; ld.bu/ld.hu zero-extend; ld.w full word.
- final_result = res_from_mem ? load_data : exe_result.
- MEM_write = MEM_valid & gr_we.
- MEM_block = MEM_valid & res_from_mem & ~ready_go. Decode stalls on a dest match while set, and may bypass final_result when clear.
- Latency: non-load, or load with data_ok in the same cycle: 1 cycle in stage. Load otherwise: 1 + cycles until data_ok.
- Back-pressure: while ~WB_allow_in, the bus register and rbuf hold, and MEM_to_WB_bus stays stable.
- Reset mid-operation: MEM_valid, rbuf_valid and the counter go to 0 next edge; a pending load is dropped; any later stray data_ok is ignored.
- Reset values: MEM_to_WB_valid 0, MEM_allow_in 1, MEM_wr_bus[38:37] 0, mem_stall_cnt 0. Data fields are don't-care while invalid.

Optional Feature:
- MEM_STALL_CNT_EN defined:
  - 32-bit counter increments each cycle MEM_valid & res_from_mem & ~ready_go.
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared only by reset.
  - Drives mem_stall_cnt.
- Undefined: counter not instantiated; mem_stall_cnt tied to 0.

Test Plan:
- add, exe_result=0x12345678, gr_we=1, dest=5, WB_allow_in=1 -> next cycle MEM_to_WB_valid=1, final_result=0x12345678, MEM_wr_bus={1,0,5,0x12345678}.
- ld.b addr[1:0]=3, rdata=0x80FF0011, data_ok same cycle -> final_result=0xFFFFFF80; ld.bu -> 0x00000080; ld.hu addr=2 -> 0x000080FF; ld.h addr=0 -> 0x00000011.
- ld.w, data_ok delayed 3 cycles with rdata=0xCAFEBABE -> MEM_block=1 and MEM_allow_in=0 for 3 cycles, then result 0xCAFEBABE; mem_stall_cnt=3 with MEM_STALL_CNT_EN, 0 without.
- ld.w, data_ok pulses with 0xDEADBEEF while WB_allow_in=0 for 4 cycles, rdata then changes to 0 -> bus holds 0xDEADBEEF; accepted when WB_allow_in=1; rbuf_valid cleared.
- Back-to-back non-loads, WB_allow_in=1 -> full throughput, MEM_allow_in=1 every cycle.
- Assert reset during a pending load, then stray data_ok -> MEM_to_WB_valid stays 0, MEM_wr_bus[38:37]=0.
